// File: rtl/count_display_driver.sv
// Registers a 4-bit upstream count, shows it as two multiplexed decimal digits
// on a common-segment seven-segment display, and tallies 15->0 counter wraps.
module count_display_driver #(
  parameter int REFRESH_DIV = 4,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] count,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap_pulse,
  output logic [3:0] wrap_count
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  logic [3:0]    count_q;
  logic [3:0]    prev_q;
  logic [RW-1:0] refresh_q;
  logic [RW-1:0] refresh_next;
  logic          digit_sel_q;
  logic          digit_sel_next;
  logic          refresh_last;
  logic          tens;
  logic [3:0]    ones;
  logic [3:0]    digit;
  logic          blank;
  logic [6:0]    seg_hi;
  logic [6:0]    seg_drive;
  logic [1:0]    an_hi;
  logic [1:0]    an_drive;
  logic          wrap_det;
  logic [6:0]    seg_reg;
  logic [1:0]    an_reg;
  logic          wrap_pulse_reg;
  logic [3:0]    wrap_count_reg;

  always_comb begin
    tens           = (count_q >= 4'd10);
    ones           = tens ? (count_q - 4'd10) : count_q;
    refresh_last   = (refresh_q == REF_LAST);
    refresh_next   = refresh_last ? '0 : refresh_q + 1'b1;
    digit_sel_next = digit_sel_q ^ refresh_last;
    // Outputs follow the slot being entered so the enable switches on the toggle edge.
    digit          = digit_sel_next ? {3'b000, tens} : ones;
    blank          = digit_sel_next && !tens;
    an_hi          = digit_sel_next ? 2'b10 : 2'b01;
    wrap_det       = (prev_q == 4'd15) && (count_q == 4'd0);
    seg_hi         = 7'b0000000;
    case (digit)
      4'd0:    seg_hi = 7'b0111111;
      4'd1:    seg_hi = 7'b0000110;
      4'd2:    seg_hi = 7'b1011011;
      4'd3:    seg_hi = 7'b1001111;
      4'd4:    seg_hi = 7'b1100110;
      4'd5:    seg_hi = 7'b1101101;
      4'd6:    seg_hi = 7'b1111101;
      4'd7:    seg_hi = 7'b0000111;
      4'd8:    seg_hi = 7'b1111111;
      4'd9:    seg_hi = 7'b1101111;
      default: seg_hi = 7'b0000000;
    endcase
    if (blank) begin
      seg_hi = 7'b0000000;
    end
  end

  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_seg_pol
      assign seg_drive[gi] = ACTIVE_LOW ? ~seg_hi[gi] : seg_hi[gi];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_an_pol
      assign an_drive[gi] = ACTIVE_LOW ? ~an_hi[gi] : an_hi[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= 4'd0;
      prev_q         <= 4'd0;
      refresh_q      <= '0;
      digit_sel_q    <= 1'b0;
      seg_reg        <= SEG_OFF;
      an_reg         <= AN_OFF;
      wrap_pulse_reg <= 1'b0;
      wrap_count_reg <= 4'd0;
    end else begin
      count_q        <= count;
      prev_q         <= count_q;
      refresh_q      <= refresh_next;
      digit_sel_q    <= digit_sel_next;
      seg_reg        <= seg_drive;
      an_reg         <= an_drive;
      wrap_pulse_reg <= wrap_det;
      if (wrap_det) begin
        wrap_count_reg <= wrap_count_reg + 4'd1;
      end
    end
  end

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign wrap_pulse = wrap_pulse_reg;
  assign wrap_count = wrap_count_reg;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver: a behavioural model queues the
// expected outputs for every edge and they are compared one edge later.
module tb_count_display_driver;

  localparam int REFRESH_DIV = 4;
  // Active-low encodings of digits 0..9 (gfedcba).
  localparam logic [6:0] SEG_LO [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [6:0] seg;
    logic [1:0] an;
    logic       wp;
    logic [3:0] wc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap_pulse;
  logic [3:0] wrap_count;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_passed = 0;
  int   pulses = 0;

  int         m_cq, m_pq, m_ref;
  logic       m_sel;
  logic [3:0] m_wc;

  count_display_driver #(.REFRESH_DIV(REFRESH_DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .seg        (seg),
    .an         (an),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      n_passed++;
    end
  endtask

  // Drive one edge worth of inputs, queue the model's prediction, then compare.
  task automatic step(input logic r, input logic [3:0] c);
    exp_t e;
    exp_t o;
    int   nref;
    logic nsel;
    @(negedge clk);
    reset = r;
    count = c;
    if (r) begin
      e = '{seg: 7'h7F, an: 2'b11, wp: 1'b0, wc: 4'd0};
      m_cq = 0; m_pq = 0; m_ref = 0; m_sel = 1'b0; m_wc = 4'd0;
    end else begin
      if (m_ref == REFRESH_DIV - 1) begin
        nref = 0;
        nsel = ~m_sel;
      end else begin
        nref = m_ref + 1;
        nsel = m_sel;
      end
      e.an  = nsel ? 2'b01 : 2'b10;
      e.seg = nsel ? ((m_cq >= 10) ? SEG_LO[1] : 7'h7F) : SEG_LO[m_cq % 10];
      e.wp  = (m_pq == 15) && (m_cq == 0);
      m_wc  = m_wc + {3'b000, e.wp};
      e.wc  = m_wc;
      m_pq  = m_cq;
      m_cq  = int'(c);
      m_ref = nref;
      m_sel = nsel;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    if (wrap_pulse === 1'b1) pulses++;
    $display("t=%0t rst=%0b count=%0d seg=%h an=%b wp=%0b wc=%0d", $time, r, c,
             seg, an, wrap_pulse, wrap_count);
    check("seg", 8'(seg), 8'(o.seg));
    check("an", 8'(an), 8'(o.an));
    check("wrap_pulse", 8'(wrap_pulse), 8'(o.wp));
    check("wrap_count", 8'(wrap_count), 8'(o.wc));
  endtask

  initial begin
    int   edge_no;
    logic [3:0] seq5 [7];
    logic [3:0] seq6 [6];

    // 1: reset for two cycles
    step(1'b1, 4'd0);
    step(1'b1, 4'd0);
    check("rst_seg", 8'(seg), 8'h7F);
    check("rst_an", 8'(an), 8'(2'b11));

    // 2: hold 7, ones slot then blanked tens slot
    step(1'b0, 4'd7);
    step(1'b0, 4'd7);
    check("ones7_seg", 8'(seg), 8'(7'b1111000));
    check("ones7_an", 8'(an), 8'(2'b10));
    step(1'b0, 4'd7);
    step(1'b0, 4'd7);
    check("tens_blank_seg", 8'(seg), 8'h7F);
    check("tens_blank_an", 8'(an), 8'(2'b01));
    for (int i = 0; i < 4; i++) step(1'b0, 4'd7);
    check("alt_ones_an", 8'(an), 8'(2'b10));

    // 3: switch to 12, visible two edges later
    step(1'b0, 4'd12);
    check("lat1_seg", 8'(seg), 8'(7'b1111000));
    step(1'b0, 4'd12);
    check("lat2_seg", 8'(seg), 8'(7'b0100100));
    step(1'b0, 4'd12);
    step(1'b0, 4'd12);
    check("tens1_seg", 8'(seg), 8'(7'b1111001));
    check("tens1_an", 8'(an), 8'(2'b01));

    // 4: free-running upstream counter
    pulses = 0;
    for (int i = 0; i < 42; i++) step(1'b0, 4'(i));
    check("free_pulses", 8'(pulses), 8'd2);
    check("free_wc", 8'(wrap_count), 8'd2);

    // 5: 14,0,15,15,0 -> only the final 15->0 counts
    seq5 = '{4'd14, 4'd0, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0};
    pulses = 0;
    for (int i = 0; i < 7; i++) step(1'b0, seq5[i]);
    check("seq_pulses", 8'(pulses), 8'd1);
    check("seq_wc", 8'(wrap_count), 8'd3);

    // bring the tally to 5
    seq6 = '{4'd15, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 6; i++) step(1'b0, seq6[i]);
    check("wc5", 8'(wrap_count), 8'd5);

    // 6: reset during a tens slot
    edge_no = 0;
    while (m_sel !== 1'b1 && edge_no < 10) begin
      step(1'b0, 4'd3);
      edge_no++;
    end
    check("reach_tens_slot", 8'(m_sel), 8'd1);
    step(1'b1, 4'd15);
    check("mid_rst_seg", 8'(seg), 8'h7F);
    check("mid_rst_wc", 8'(wrap_count), 8'd0);
    edge_no = 0;
    for (int i = 1; i <= 2 * REFRESH_DIV; i++) begin
      step(1'b0, 4'd0);
      if (edge_no == 0 && an === 2'b01) edge_no = i;
    end
    check("first_tens_edge", 8'(edge_no), 8'(REFRESH_DIV));

    // reset coinciding with a wrap edge wins
    step(1'b0, 4'd15);
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    check("pre_wc", 8'(wrap_count), 8'd1);
    step(1'b0, 4'd15);
    step(1'b0, 4'd0);
    step(1'b1, 4'd0);
    check("rst_wrap_wp", 8'(wrap_pulse), 8'd0);
    check("rst_wrap_wc", 8'(wrap_count), 8'd0);
    step(1'b0, 4'd0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
